// File: rtl/cdb_arbiter.sv
// cdb_arbiter: collects results from three execution units (ALU, load/store,
// branch) into small per-source FIFOs and broadcasts at most one result per
// cycle on the common data bus, choosing among non-empty queues round-robin.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   ena                global enable; low freezes every register
//   in_flush           rollback; empties all queues and idles the bus
//   in_<src>_valid     result strobe from ALU / LS / BR
//   in_<src>_rob_tag   destination ROB tag (tag 0 means "no tag", ignored)
//   in_<src>_data      result value
//   out_<src>_full     queue holds FIFO_DEPTH entries (from registered count)
//   out_cdb_valid/rob_tag/data/src   registered broadcast (src 0 ALU, 1 LS, 2 BR)
//   out_overflow       sticky: a tagged result was dropped at a full queue

`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module cdb_arbiter #(
  parameter int ROB_W      = `ROB_WIDTH,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_flush,
  input  logic              in_alu_valid,
  input  logic [ROB_W-1:0]  in_alu_rob_tag,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic              in_ls_valid,
  input  logic [ROB_W-1:0]  in_ls_rob_tag,
  input  logic [DATA_W-1:0] in_ls_data,
  input  logic              in_br_valid,
  input  logic [ROB_W-1:0]  in_br_rob_tag,
  input  logic [DATA_W-1:0] in_br_data,
  output logic              out_alu_full,
  output logic              out_ls_full,
  output logic              out_br_full,
  output logic              out_cdb_valid,
  output logic [ROB_W-1:0]  out_cdb_rob_tag,
  output logic [DATA_W-1:0] out_cdb_data,
  output logic [1:0]        out_cdb_src,
  output logic              out_overflow
);

  localparam int NSRC  = 3;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(32'd1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ROB_W-1:0]  ZERO_ROB  = {ROB_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
  localparam logic [1:0]        SRC_ALU   = 2'd0;

  // Advance a queue pointer, wrapping at FIFO_DEPTH (works for any depth).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = PTR_ZERO;
    end else begin
      nxt = ptr + PTR_ONE;
    end
    return nxt;
  endfunction

  // Next source id modulo 3.
  function automatic logic [1:0] src_inc(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Round-robin search starting at prio; returns {found, selected source}.
  // An illegal prio of 3 is treated as ALU so the arbiter self-recovers.
  function automatic logic [2:0] rr_pick(input logic [1:0] prio, input logic [2:0] req);
    logic [1:0] idx;
    logic       found;
    logic [1:0] sel;
    found = 1'b0;
    sel   = 2'd0;
    idx   = (prio == 2'd3) ? 2'd0 : prio;
    for (int k = 0; k < NSRC; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end else begin
        found = found;
        sel   = sel;
      end
      idx = src_inc(idx);
    end
    return {found, sel};
  endfunction

  // Per-source input views, indexed by source id.
  logic [NSRC-1:0]   in_valid_s;
  logic [ROB_W-1:0]  in_tag_s  [NSRC];
  logic [DATA_W-1:0] in_data_s [NSRC];

  assign in_valid_s   = {in_br_valid, in_ls_valid, in_alu_valid};
  assign in_tag_s[0]  = in_alu_rob_tag;
  assign in_tag_s[1]  = in_ls_rob_tag;
  assign in_tag_s[2]  = in_br_rob_tag;
  assign in_data_s[0] = in_alu_data;
  assign in_data_s[1] = in_ls_data;
  assign in_data_s[2] = in_br_data;

  // Queue storage and bookkeeping.
  logic [ROB_W-1:0]  tag_mem_q  [NSRC][FIFO_DEPTH];
  logic [ROB_W-1:0]  tag_mem_d  [NSRC][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [NSRC][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_d [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  head_q  [NSRC];
  logic [PTR_W-1:0]  head_d  [NSRC];
  logic [PTR_W-1:0]  tail_q  [NSRC];
  logic [PTR_W-1:0]  tail_d  [NSRC];
  logic [CNT_W-1:0]  count_q [NSRC];
  logic [CNT_W-1:0]  count_d [NSRC];

  logic [1:0]        prio_q, prio_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [1:0]        cdb_src_q, cdb_src_d;
  logic              overflow_q, overflow_d;

  logic [NSRC-1:0]   full_s;
  logic [NSRC-1:0]   nonempty_s;
  logic [2:0]        pick_s;
  logic              grant_valid_s;
  logic [1:0]        grant_idx_s;
  logic [NSRC-1:0]   push_s;
  logic [NSRC-1:0]   pop_s;
  logic [NSRC-1:0]   drop_s;

  // Status from registered counts; arbitration never sees this cycle's pushes.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      full_s[i]     = (count_q[i] == CNT_FULL);
      nonempty_s[i] = (count_q[i] != CNT_ZERO);
    end
  end

  assign pick_s        = rr_pick(prio_q, nonempty_s);
  assign grant_valid_s = pick_s[2];
  assign grant_idx_s   = pick_s[1:0];

  // Next-state logic: enable hold, flush, then normal pop/push per source.
  always_comb begin
    tag_mem_d   = tag_mem_q;
    data_mem_d  = data_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    prio_d      = prio_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    push_s      = 3'b000;
    pop_s       = 3'b000;
    drop_s      = 3'b000;

    if (!ena) begin
      // Frozen: every register keeps its value, inputs are ignored.
      push_s = 3'b000;
    end else if (in_flush) begin
      for (int i = 0; i < NSRC; i++) begin
        head_d[i]  = PTR_ZERO;
        tail_d[i]  = PTR_ZERO;
        count_d[i] = CNT_ZERO;
      end
      prio_d      = SRC_ALU;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = ZERO_ROB;
      cdb_data_d  = ZERO_DATA;
      cdb_src_d   = SRC_ALU;
    end else begin
      if (grant_valid_s) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = tag_mem_q[grant_idx_s][head_q[grant_idx_s]];
        cdb_data_d  = data_mem_q[grant_idx_s][head_q[grant_idx_s]];
        cdb_src_d   = grant_idx_s;
        prio_d      = src_inc(grant_idx_s);
      end else begin
        cdb_valid_d = 1'b0;
        cdb_tag_d   = ZERO_ROB;
        cdb_data_d  = ZERO_DATA;
        cdb_src_d   = SRC_ALU;
      end

      for (int i = 0; i < NSRC; i++) begin
        pop_s[i] = grant_valid_s && (grant_idx_s == 2'(i));
        // Full is judged on the registered count, so a pop in the same cycle
        // does not make room for a push into a full queue.
        push_s[i] = in_valid_s[i] && (in_tag_s[i] != ZERO_ROB) && !full_s[i];
        drop_s[i] = in_valid_s[i] && (in_tag_s[i] != ZERO_ROB) && full_s[i];

        if (push_s[i]) begin
          tag_mem_d[i][tail_q[i]]  = in_tag_s[i];
          data_mem_d[i][tail_q[i]] = in_data_s[i];
          tail_d[i]                = ptr_inc(tail_q[i]);
        end else begin
          tail_d[i] = tail_q[i];
        end

        if (pop_s[i]) begin
          head_d[i] = ptr_inc(head_q[i]);
        end else begin
          head_d[i] = head_q[i];
        end

        case ({push_s[i], pop_s[i]})
          2'b10:   count_d[i] = count_q[i] + CNT_ONE;
          2'b01:   count_d[i] = count_q[i] - CNT_ONE;
          default: count_d[i] = count_q[i];
        endcase
      end
    end

    overflow_d = overflow_q | (|drop_s);
  end

  // State registers with synchronous reset that overrides ena and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        head_q[i]  <= PTR_ZERO;
        tail_q[i]  <= PTR_ZERO;
        count_q[i] <= CNT_ZERO;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          tag_mem_q[i][j]  <= ZERO_ROB;
          data_mem_q[i][j] <= ZERO_DATA;
        end
      end
      prio_q      <= SRC_ALU;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= ZERO_ROB;
      cdb_data_q  <= ZERO_DATA;
      cdb_src_q   <= SRC_ALU;
      overflow_q  <= 1'b0;
    end else begin
      tag_mem_q   <= tag_mem_d;
      data_mem_q  <= data_mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      prio_q      <= prio_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_alu_full    = full_s[0];
  assign out_ls_full     = full_s[1];
  assign out_br_full     = full_s[2];
  assign out_cdb_valid   = cdb_valid_q;
  assign out_cdb_rob_tag = cdb_tag_q;
  assign out_cdb_data    = cdb_data_q;
  assign out_cdb_src     = cdb_src_q;
  assign out_overflow    = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int ROB_W  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int VW     = 1 + ROB_W + DATA_W + 2 + 3 + 1;

  logic clk = 1'b0;
  logic rst, ena, in_flush;
  logic              v [3];
  logic [ROB_W-1:0]  t [3];
  logic [DATA_W-1:0] d [3];
  logic out_alu_full, out_ls_full, out_br_full;
  logic out_cdb_valid, out_overflow;
  logic [ROB_W-1:0]  out_cdb_rob_tag;
  logic [DATA_W-1:0] out_cdb_data;
  logic [1:0]        out_cdb_src;
  logic [VW-1:0]     dut_vec;

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_W(ROB_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_flush(in_flush),
    .in_alu_valid(v[0]), .in_alu_rob_tag(t[0]), .in_alu_data(d[0]),
    .in_ls_valid(v[1]),  .in_ls_rob_tag(t[1]),  .in_ls_data(d[1]),
    .in_br_valid(v[2]),  .in_br_rob_tag(t[2]),  .in_br_data(d[2]),
    .out_alu_full(out_alu_full), .out_ls_full(out_ls_full), .out_br_full(out_br_full),
    .out_cdb_valid(out_cdb_valid), .out_cdb_rob_tag(out_cdb_rob_tag),
    .out_cdb_data(out_cdb_data), .out_cdb_src(out_cdb_src),
    .out_overflow(out_overflow)
  );

  assign dut_vec = {out_cdb_valid, out_cdb_rob_tag, out_cdb_data, out_cdb_src,
                    out_br_full, out_ls_full, out_alu_full, out_overflow};

  // ---------------- reference model ----------------
  logic [ROB_W+DATA_W-1:0] mq0[$], mq1[$], mq2[$];
  int                m_ptr   = 0;
  logic              m_valid = 1'b0;
  logic [ROB_W-1:0]  m_tag   = '0;
  logic [DATA_W-1:0] m_data  = '0;
  logic [1:0]        m_src   = 2'd0;
  logic              m_ovf   = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int qsize(int s);
    case (s)
      0:       return mq0.size();
      1:       return mq1.size();
      default: return mq2.size();
    endcase
  endfunction

  task automatic qpush(int s, logic [ROB_W+DATA_W-1:0] e);
    case (s)
      0:       mq0.push_back(e);
      1:       mq1.push_back(e);
      default: mq2.push_back(e);
    endcase
  endtask

  task automatic qpop(int s, output logic [ROB_W+DATA_W-1:0] e);
    case (s)
      0:       e = mq0.pop_front();
      1:       e = mq1.pop_front();
      default: e = mq2.pop_front();
    endcase
  endtask

  task automatic model_idle();
    m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 2'd0;
  endtask

  task automatic model_clear();
    mq0.delete(); mq1.delete(); mq2.delete();
    m_ptr = 0;
    model_idle();
  endtask

  // Apply one clock edge's worth of behaviour using the current inputs.
  task automatic model_edge();
    int sz[3];
    int s;
    logic found;
    logic [ROB_W+DATA_W-1:0] e;
    if (rst) begin
      model_clear();
      m_ovf = 1'b0;
    end else if (!ena) begin
      found = 1'b0;
    end else if (in_flush) begin
      model_clear();
    end else begin
      for (int i = 0; i < 3; i++) sz[i] = qsize(i);
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        s = (m_ptr + k) % 3;
        if (!found && sz[s] > 0) begin
          found = 1'b1;
          qpop(s, e);
          m_valid = 1'b1;
          m_tag   = e[ROB_W+DATA_W-1:DATA_W];
          m_data  = e[DATA_W-1:0];
          m_src   = 2'(s);
          m_ptr   = (s + 1) % 3;
        end
      end
      if (!found) model_idle();
      for (int i = 0; i < 3; i++) begin
        if (v[i] && t[i] != '0) begin
          if (sz[i] == DEPTH) m_ovf = 1'b1;
          else qpush(i, {t[i], d[i]});
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_tag, m_data, m_src,
            qsize(2) == DEPTH, qsize(1) == DEPTH, qsize(0) == DEPTH, m_ovf};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin v[i] = 1'b0; t[i] = '0; d[i] = '0; end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 3; i++) begin
      v[i] = ($urandom_range(0, 99) < 60);
      t[i] = 4'($urandom_range(0, 15));
      d[i] = $urandom;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; in_flush = 1'b1; rand_inputs();
    tick();
    rst = 1'b0; ena = 1'b1; in_flush = 1'b0; idle_inputs();
    n_checks++;
    if (dut_vec !== {VW{1'b0}}) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, {VW{1'b0}});
    end
  endtask

  task automatic test_single_push();
    v[0] = 1'b1; t[0] = 4'd3; d[0] = 32'h11;
    tick();
    idle_inputs();
    n_checks++;
    if (dut_vec !== exp_vec() || out_cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_edge1: got %h expected %h", dut_vec, exp_vec());
    end
    tick();
    n_checks++;
    if (dut_vec !== exp_vec() || {out_cdb_valid, out_cdb_rob_tag, out_cdb_data, out_cdb_src}
        !== {1'b1, 4'd3, 32'h11, 2'd0}) begin
      n_fail++; $display("FAIL single_edge2: got %h expected %h", dut_vec, exp_vec());
    end
    tick();
    n_checks++;
    if (dut_vec !== exp_vec() || out_cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_edge3: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_round_robin();
    logic [ROB_W-1:0] exp_tags [5];
    logic [1:0]       exp_srcs [5];
    exp_tags = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    exp_srcs = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    rst = 1'b1; tick(); rst = 1'b0;
    v = '{1'b1, 1'b1, 1'b1}; t = '{4'd1, 4'd2, 4'd3}; d = '{32'hA1, 32'hA2, 32'hA3};
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || out_cdb_valid !== 1'b1 ||
          out_cdb_rob_tag !== exp_tags[c] || out_cdb_src !== exp_srcs[c]) begin
        n_fail++; $display("FAIL rr_first%0d: got %h expected tag %0d (model %h)", c, dut_vec, exp_tags[c], exp_vec());
      end
    end
    v[0] = 1'b1; t[0] = 4'd4; d[0] = 32'hB4;
    v[1] = 1'b1; t[1] = 4'd5; d[1] = 32'hB5;
    tick();
    idle_inputs();
    for (int c = 3; c < 5; c++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || out_cdb_valid !== 1'b1 ||
          out_cdb_rob_tag !== exp_tags[c] || out_cdb_src !== exp_srcs[c]) begin
        n_fail++; $display("FAIL rr_second%0d: got %h expected tag %0d (model %h)", c, dut_vec, exp_tags[c], exp_vec());
      end
    end
  endtask

  task automatic test_tag_zero();
    v[2] = 1'b1; t[2] = 4'd0; d[2] = 32'hFF;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (dut_vec !== exp_vec() || out_cdb_valid !== 1'b0 || out_overflow !== 1'b0 || out_br_full !== 1'b0) begin
        n_fail++; $display("FAIL tag_zero%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_flush();
    v = '{1'b1, 1'b1, 1'b1}; t = '{4'd1, 4'd2, 4'd3}; d = '{32'hC1, 32'hC2, 32'hC3};
    tick();
    idle_inputs();
    in_flush = 1'b1; v[0] = 1'b1; t[0] = 4'd9; d[0] = 32'h99;
    tick();
    in_flush = 1'b0; idle_inputs();
    n_checks++;
    if (dut_vec !== exp_vec() || dut_vec[VW-1:1] !== {(VW-1){1'b0}}) begin
      n_fail++; $display("FAIL flush_idle: got %h expected %h", dut_vec, exp_vec());
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || out_cdb_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_after%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_overflow();
    logic [ROB_W-1:0] ls_seen[$];
    in_flush = 1'b1; tick(); in_flush = 1'b0;
    v = '{1'b1, 1'b1, 1'b1}; t = '{4'd10, 4'd6, 4'd12}; d = '{32'hD0, 32'hD6, 32'hD2};
    tick();
    v = '{1'b1, 1'b1, 1'b1}; t = '{4'd11, 4'd7, 4'd13}; d = '{32'hD1, 32'hD7, 32'hD3};
    tick();
    n_checks++;
    if (dut_vec !== exp_vec() || out_ls_full !== 1'b1) begin
      n_fail++; $display("FAIL ovf_ls_full: got %h expected %h", dut_vec, exp_vec());
    end
    idle_inputs();
    v[1] = 1'b1; t[1] = 4'd8; d[1] = 32'hD8;
    tick();
    if (out_cdb_valid && out_cdb_src == 2'd1) ls_seen.push_back(out_cdb_rob_tag);
    idle_inputs();
    n_checks++;
    if (dut_vec !== exp_vec() || out_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: got %h expected %h", dut_vec, exp_vec());
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_cdb_valid && out_cdb_src == 2'd1) ls_seen.push_back(out_cdb_rob_tag);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL ovf_drain%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (ls_seen.size() != 2 || ls_seen[0] !== 4'd6 || ls_seen[1] !== 4'd7) begin
      n_fail++; $display("FAIL ovf_ls_order: got %0d tags expected 6,7", ls_seen.size());
    end
  endtask

  task automatic test_enable();
    v[0] = 1'b1; t[0] = 4'd5; d[0] = 32'h55;
    tick();
    ena = 1'b0; in_flush = 1'b1; idle_inputs();
    v[1] = 1'b1; t[1] = 4'd7; d[1] = 32'h77;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || out_cdb_valid !== 1'b0 || out_overflow !== 1'b1) begin
        n_fail++; $display("FAIL ena_frozen%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    ena = 1'b1; in_flush = 1'b0; idle_inputs();
    tick();
    n_checks++;
    if (dut_vec !== exp_vec() || {out_cdb_valid, out_cdb_rob_tag, out_cdb_data} !== {1'b1, 4'd5, 32'h55}) begin
      n_fail++; $display("FAIL ena_resume: got %h expected %h", dut_vec, exp_vec());
    end
    tick();
    n_checks++;
    if (dut_vec !== exp_vec() || out_cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL ena_ignored_push: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      ena      = ($urandom_range(0, 7) != 0);
      in_flush = ($urandom_range(0, 19) == 0);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    ena = 1'b1; in_flush = 1'b0; idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 15; c++) begin
      rand_inputs();
      tick();
    end
    rst = 1'b1; rand_inputs(); ena = 1'b0;
    tick();
    rst = 1'b0; ena = 1'b1; idle_inputs();
    n_checks++;
    if (dut_vec !== {VW{1'b0}} || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_mid: got %h expected %h", dut_vec, {VW{1'b0}});
    end
    tick();
    n_checks++;
    if (dut_vec !== exp_vec() || {out_alu_full, out_ls_full, out_br_full, out_cdb_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_after: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; in_flush = 1'b0;
    idle_inputs();
    test_reset();
    test_single_push();
    test_round_robin();
    test_tag_zero();
    test_flush();
    test_overflow();
    test_enable();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
